pool_window_gather: RTL and testbench

Upstream feeder for the 8-lane pooling array. Collects a stream of 8-bit activations per lane (8 lanes in parallel) into pooling windows of P consecutive samples, and presents each completed window as a 56-bit, 7-byte word with a one-cycle valid pulse. It sits between the convolution output path and the 8-lane pooling stage; its window outputs connect one-to-one to that stage's data and valid inputs.

---
 rtl/pool_pkg.sv | 16 +
 rtl/pool_lane_stage.sv | 62 ++++++
 rtl/pool_window_gather.sv | 91 +++++++++
 tb/tb_pool_window_gather.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared constants and helpers for the pooling window gather block.
// Window geometry, lane count, default pad byte, P sanitising.
package pool_pkg;

  localparam int BYTE_W    = 8;
  localparam int WIN_BYTES = 7;
  localparam int WIN_W     = 56;
  localparam int LANES     = 8;

  localparam logic [7:0] PAD_DEFAULT = 8'h80;

  function automatic logic [2:0] p_sanitize(input logic [2:0] p);
    return (p == 3'd0) ? 3'd1 : p;
  endfunction

endpackage

// File: rtl/pool_lane_stage.sv
// One lane: 7-byte staging, pad merge on close, registered window out.
// Ports: clk/rst_n, clr, wr+slot+din write, close+n_fill+en, win_data/win_vld.
module pool_lane_stage
  import pool_pkg::*;
#(
  parameter logic [7:0] PAD_BYTE = PAD_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr,
  input  logic [2:0]       slot,
  input  logic [7:0]       din,
  input  logic             close,
  input  logic [2:0]       n_fill,
  input  logic             en,
  output logic [WIN_W-1:0] win_data,
  output logic             win_vld
);

  logic [WIN_W-1:0] stg_q, stg_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic             vld_q, vld_d;
  logic [WIN_W-1:0] merged;

  always_comb begin
    merged = stg_q;
    if (wr) merged[int'(slot)*BYTE_W +: BYTE_W] = din;
    stg_d = stg_q;
    win_d = win_q;
    vld_d = 1'b0;
    if (clr) begin
      stg_d = '0;
    end else if (wr) begin
      stg_d = merged;
    end
    if (close) begin
      // slots past the collected samples are padded
      for (int i = 0; i < WIN_BYTES; i++) begin
        win_d[i*BYTE_W +: BYTE_W] =
          (3'(i) < n_fill) ? merged[i*BYTE_W +: BYTE_W] : PAD_BYTE;
      end
      vld_d = en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_q <= '0;
      win_q <= '0;
      vld_q <= 1'b0;
    end else begin
      stg_q <= stg_d;
      win_q <= win_d;
      vld_q <= vld_d;
    end
  end

  assign win_data = win_q;
  assign win_vld  = vld_q;

endmodule

// File: rtl/pool_window_gather.sv
// Gathers per-lane samples into P-sample pooling windows for 8 lanes.
// Ports: clk_cal/rst_cal_n, P, clr, lane_en, in_*, win_data/win_vld/win_cnt.
module pool_window_gather
  import pool_pkg::*;
#(
  parameter logic [7:0] PAD_BYTE = 8'h80,
  parameter int         LANES    = 8
) (
  input  logic                 clk_cal,
  input  logic                 rst_cal_n,
  input  logic [2:0]           P,
  input  logic                 clr,
  input  logic [LANES-1:0]     lane_en,
  input  logic                 in_vld,
  input  logic [LANES*8-1:0]   in_data,
  input  logic                 in_last,
  output logic [LANES*56-1:0]  win_data,
  output logic [LANES-1:0]     win_vld,
  output logic [15:0]          win_cnt
);

  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  p_lat_q, p_lat_d;
  logic [15:0] win_cnt_q, win_cnt_d;
  logic [2:0]  p_cur;
  logic [2:0]  n_fill;
  logic        wr;
  logic        close;

  always_comb begin
    // a new window latches P on its first sample
    p_cur  = (cnt_q == 3'd0) ? p_sanitize(P) : p_lat_q;
    n_fill = in_vld ? cnt_q + 3'd1 : cnt_q;
    wr     = in_vld & ~clr;
    close  = 1'b0;
    if (!clr) begin
      if (in_vld)
        close = (cnt_q == p_cur - 3'd1) | in_last;
      else
        close = in_last & (cnt_q != 3'd0);
    end
    cnt_d     = cnt_q;
    p_lat_d   = p_lat_q;
    win_cnt_d = win_cnt_q;
    if (clr) begin
      cnt_d     = 3'd0;
      win_cnt_d = 16'd0;
    end else begin
      if (in_vld && cnt_q == 3'd0) p_lat_d = p_cur;
      if (close) begin
        cnt_d     = 3'd0;
        win_cnt_d = win_cnt_q + 16'd1;
      end else if (in_vld) begin
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_cal or negedge rst_cal_n) begin
    if (!rst_cal_n) begin
      cnt_q     <= 3'd0;
      p_lat_q   <= 3'd1;
      win_cnt_q <= 16'd0;
    end else begin
      cnt_q     <= cnt_d;
      p_lat_q   <= p_lat_d;
      win_cnt_q <= win_cnt_d;
    end
  end

  assign win_cnt = win_cnt_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    pool_lane_stage #(
      .PAD_BYTE(PAD_BYTE)
    ) u_lane (
      .clk     (clk_cal),
      .rst_n   (rst_cal_n),
      .clr     (clr),
      .wr      (wr),
      .slot    (cnt_q),
      .din     (in_data[8*k +: 8]),
      .close   (close),
      .n_fill  (n_fill),
      .en      (lane_en[k]),
      .win_data(win_data[56*k +: 56]),
      .win_vld (win_vld[k])
    );
  end

endmodule

// File: tb/tb_pool_window_gather.sv
// Scoreboard bench for pool_window_gather: directed windows, clr, reset, wrap.
// Stimulus pushes expected windows; a negedge monitor pops and compares.
module tb_pool_window_gather;

  typedef struct {
    logic [7:0]   vld;
    logic [55:0]  win;
    logic [15:0]  cnt;
  } exp_t;

  logic         clk_cal = 1'b0;
  logic         rst_cal_n = 1'b0;
  logic [2:0]   P = 3'd1;
  logic         clr = 1'b0;
  logic [7:0]   lane_en = 8'hFF;
  logic         in_vld = 1'b0;
  logic [63:0]  in_data = '0;
  logic         in_last = 1'b0;
  logic [447:0] win_data;
  logic [7:0]   win_vld;
  logic [15:0]  win_cnt;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk_cal = ~clk_cal;

  pool_window_gather dut (
    .clk_cal  (clk_cal),
    .rst_cal_n(rst_cal_n),
    .P        (P),
    .clr      (clr),
    .lane_en  (lane_en),
    .in_vld   (in_vld),
    .in_data  (in_data),
    .in_last  (in_last),
    .win_data (win_data),
    .win_vld  (win_vld),
    .win_cnt  (win_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, req);
    end
  endtask

  task automatic push(input logic [7:0] v, input logic [55:0] w,
                      input logic [15:0] c);
    exp_t e;
    e.vld = v;
    e.win = w;
    e.cnt = c;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic v, input logic [7:0] b,
                     input logic last, input logic c);
    in_vld  = v;
    in_data = {8{b}};
    in_last = last;
    clr     = c;
    @(posedge clk_cal);
    #1;
    in_vld  = 1'b0;
    in_last = 1'b0;
    clr     = 1'b0;
  endtask

  always @(negedge clk_cal) begin
    if (rst_cal_n && win_vld != 8'h00) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_window: got vld %h cnt %0d, want none",
                 win_vld, win_cnt);
      end else begin
        exp_t e;
        logic ok;
        e  = exp_q.pop_front();
        ok = (win_vld === e.vld) && (win_cnt === e.cnt);
        for (int k = 0; k < 8; k++)
          if (e.vld[k] && win_data[56*k +: 56] !== e.win) ok = 1'b0;
        n_chk++;
        if (!ok) begin
          n_fail++;
          $display("FAIL window: got vld %h cnt %h lane0 %h, want vld %h cnt %h win %h",
                   win_vld, win_cnt, win_data[55:0], e.vld, e.cnt, e.win);
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk_cal);
    #1 rst_cal_n = 1'b1;
    @(posedge clk_cal);
    #1;
    chk("reset_win_vld", 64'(win_vld), 64'h0);
    chk("reset_win_data", win_data[63:0], 64'h0);
    chk("reset_win_cnt", 64'(win_cnt), 64'h0);

    // P=3 basic window
    P = 3'd3;
    cyc(1, 8'h01, 0, 0);
    cyc(1, 8'h02, 0, 0);
    push(8'hFF, 56'h80808080030201, 16'd1);
    cyc(1, 8'h03, 0, 0);

    // P=7 full window
    P = 3'd7;
    for (int i = 0; i < 6; i++) cyc(1, 8'h10 + 8'(i), 0, 0);
    push(8'hFF, 56'h16151413121110, 16'd2);
    cyc(1, 8'h16, 0, 0);

    // P=4, in_last flush after two samples
    P = 3'd4;
    cyc(1, 8'hB1, 0, 0);
    cyc(1, 8'hB2, 0, 0);
    push(8'hFF, 56'h808080808080B2 << 0 | 56'h0, 16'd0);
    void'(exp_q.pop_back());
    push(8'hFF, 56'h8080808080B2B1, 16'd3);
    cyc(0, 8'h00, 1, 0);
    // idle in_last with nothing pending does nothing
    cyc(0, 8'h00, 1, 0);
    P = 3'd1;
    push(8'hFF, 56'h808080808080C1, 16'd4);
    cyc(1, 8'hC1, 0, 0);

    // P changes mid-window
    P = 3'd2;
    cyc(1, 8'h21, 0, 0);
    P = 3'd5;
    push(8'hFF, 56'h80808080802221, 16'd5);
    cyc(1, 8'h22, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 8'h31 + 8'(i), 0, 0);
    push(8'hFF, 56'h80803534333231, 16'd6);
    cyc(1, 8'h35, 0, 0);

    // in_vld with in_last closes including the current byte
    cyc(1, 8'h71, 0, 0);
    push(8'hFF, 56'h80808080807271, 16'd7);
    cyc(1, 8'h72, 1, 0);

    // partial lane enable, P=1
    cyc(0, 8'h00, 0, 1);
    chk("clr_cnt_a", 64'(win_cnt), 64'h0);
    lane_en = 8'h0F;
    P = 3'd1;
    push(8'h0F, 56'h80808080808041, 16'd1);
    push(8'h0F, 56'h80808080808042, 16'd2);
    push(8'h0F, 56'h80808080808043, 16'd3);
    cyc(1, 8'h41, 0, 0);
    cyc(1, 8'h42, 0, 0);
    cyc(1, 8'h43, 0, 0);
    @(posedge clk_cal);
    #1;
    chk("lane_en_cnt", 64'(win_cnt), 64'd3);

    // clr with pending samples and a same-cycle sample
    lane_en = 8'hFF;
    P = 3'd3;
    cyc(1, 8'h51, 0, 0);
    cyc(1, 8'h52, 0, 0);
    cyc(1, 8'h53, 0, 1);
    chk("clr_cnt_b", 64'(win_cnt), 64'h0);
    @(posedge clk_cal);
    #1;
    chk("clr_no_vld", 64'(win_vld), 64'h0);
    cyc(1, 8'h61, 0, 0);
    cyc(1, 8'h62, 0, 0);
    push(8'hFF, 56'h80808080636261, 16'd1);
    cyc(1, 8'h63, 0, 0);

    // reset mid-window emits nothing and restarts the slot counter
    cyc(1, 8'h81, 0, 0);
    rst_cal_n = 1'b0;
    #1;
    chk("rst_mid_cnt", 64'(win_cnt), 64'h0);
    chk("rst_mid_vld", 64'(win_vld), 64'h0);
    @(posedge clk_cal);
    #1 rst_cal_n = 1'b1;
    P = 3'd1;
    push(8'hFF, 56'h80808080808082, 16'd1);
    cyc(1, 8'h82, 0, 0);

    // win_cnt wrap
    cyc(0, 8'h00, 0, 1);
    P = 3'd1;
    for (int i = 0; i < 65536; i++) begin
      push(8'hFF, {48'h808080808080, 8'(i)}, 16'(i + 1));
      cyc(1, 8'(i), 0, 0);
    end
    @(posedge clk_cal);
    #1;
    chk("wrap_cnt", 64'(win_cnt), 64'h0);

    repeat (3) @(posedge clk_cal);
    chk("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
